// File: rtl/apple2_bus_pkg.sv
// Shared types and constants for the Apple II peripheral slot bus.
package apple2_bus_pkg;

  localparam int NUM_SLOTS = 7;

  typedef logic [2:0] slot_t;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } bus_state_t;

  localparam slot_t SLOT_C3 = 3'd3;

  localparam logic [15:0] ADDR_INTCXROM_OFF = 16'hC006;
  localparam logic [15:0] ADDR_INTCXROM_ON  = 16'hC007;
  localparam logic [15:0] ADDR_SLOTC3_OFF   = 16'hC00A;
  localparam logic [15:0] ADDR_SLOTC3_ON    = 16'hC00B;
  localparam logic [15:0] ADDR_C8_RELEASE   = 16'hCFFF;

endpackage

// File: rtl/apple2_slot_decode.sv
// Combinational address decode: per-slot strobes plus the internal-ROM flag.
module apple2_slot_decode
  import apple2_bus_pkg::*;
#(
  parameter logic [NUM_SLOTS-1:0] SLOT_MASK = 7'h7F
) (
  input  logic [15:0]          address,
  input  logic                 intcxrom,
  input  logic                 slotc3rom,
  input  logic                 intc8rom,
  output logic [NUM_SLOTS-1:0] dev_sel,
  output logic [NUM_SLOTS-1:0] io_sel,
  output logic                 io_strobe,
  output logic                 int_rom
);

  logic  dev_space, io_space, c8_space, io_internal;
  slot_t dev_slot, io_slot;

  assign dev_space   = (address[15:7] == 9'b1100_0000_1);
  assign dev_slot    = address[6:4];
  assign io_space    = (address[15:11] == 5'b11000) && (address[10:8] != 3'd0);
  assign io_slot     = address[10:8];
  assign c8_space    = (address[15:11] == 5'b11001);
  // Slot 3 firmware space can be taken over by the motherboard independently.
  assign io_internal = intcxrom | ((io_slot == SLOT_C3) & ~slotc3rom);

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    assign dev_sel[g] = SLOT_MASK[g] & dev_space & (dev_slot == slot_t'(g + 1));
    assign io_sel[g]  = SLOT_MASK[g] & io_space & ~io_internal & (io_slot == slot_t'(g + 1));
  end

  assign io_strobe = c8_space & ~intcxrom & ~intc8rom;
  assign int_rom   = (io_space & io_internal) | (c8_space & (intcxrom | intc8rom));

endmodule

// File: rtl/apple2_slot_bus.sv
// Apple II slot bus: PH_2-framed bus cycles, slot strobes, C800 ownership and read mux.
module apple2_slot_bus
  import apple2_bus_pkg::*;
#(
  parameter logic [NUM_SLOTS-1:0] SLOT_MASK = 7'h7F
) (
  input  logic                   CLK_14M,
  input  logic                   RESET,
  input  logic                   PH_2,
  input  logic [15:0]            ADDRESS,
  input  logic                   RW_N,
  input  logic [8*NUM_SLOTS-1:0] CARD_DO,
  input  logic [NUM_SLOTS-1:0]   CARD_ROM_EN,
  input  logic [NUM_SLOTS-1:0]   CARD_IRQ_N,
  output logic [NUM_SLOTS-1:0]   DEVICE_SELECT_N,
  output logic [NUM_SLOTS-1:0]   IO_SELECT_N,
  output logic                   IO_STROBE_N,
  output logic [7:0]             BUS_DO,
  output logic                   BUS_DO_VALID,
  output logic                   INT_ROM_SEL,
  output logic                   IRQ_N,
  output logic [2:0]             C8_OWNER
);

  bus_state_t           state;
  logic                 ph2_d, ph2_rise, ph2_fall;
  logic [15:0]          addr_q;
  logic                 rw_q;
  logic                 intcxrom, slotc3rom, intc8rom;
  logic [NUM_SLOTS-1:0] dev_q, io_q, dev_c, io_c;
  logic                 int_q, strb_c, int_c;
  logic [7:0]           rd_data;
  logic [1:0]           irq_pipe;

  apple2_slot_decode #(.SLOT_MASK(SLOT_MASK)) u_decode (
    .address   (ADDRESS),
    .intcxrom  (intcxrom),
    .slotc3rom (slotc3rom),
    .intc8rom  (intc8rom),
    .dev_sel   (dev_c),
    .io_sel    (io_c),
    .io_strobe (strb_c),
    .int_rom   (int_c)
  );

  // Edge detector tracks PH_2 even in reset so a high PH_2 at release is not a rise.
  always_ff @(posedge CLK_14M) ph2_d <= PH_2;

  assign ph2_rise = PH_2 & ~ph2_d;
  assign ph2_fall = ~PH_2 & ph2_d;

  // Read mux uses the decode captured at cycle start and the current C800 owner.
  always_comb begin
    rd_data = 8'hFF;
    if (!int_q) begin
      if (|(dev_q | io_q)) begin
        for (int n = 0; n < NUM_SLOTS; n++)
          if (dev_q[n] | io_q[n]) rd_data = CARD_DO[8*n +: 8];
      end else if (addr_q[15:11] == 5'b11001) begin
        for (int n = 0; n < NUM_SLOTS; n++)
          if ((C8_OWNER == slot_t'(n + 1)) && CARD_ROM_EN[n] && SLOT_MASK[n])
            rd_data = CARD_DO[8*n +: 8];
      end
    end
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) begin
      state           <= IDLE;
      addr_q          <= '0;
      rw_q            <= 1'b1;
      dev_q           <= '0;
      io_q            <= '0;
      int_q           <= 1'b0;
      DEVICE_SELECT_N <= '1;
      IO_SELECT_N     <= '1;
      IO_STROBE_N     <= 1'b1;
      BUS_DO          <= 8'h00;
      BUS_DO_VALID    <= 1'b0;
      INT_ROM_SEL     <= 1'b0;
      C8_OWNER        <= '0;
      intcxrom        <= 1'b0;
      slotc3rom       <= 1'b0;
      intc8rom        <= 1'b0;
    end else begin
      BUS_DO_VALID <= 1'b0;
      case (state)
        IDLE: if (ph2_rise) begin
          addr_q          <= ADDRESS;
          rw_q            <= RW_N;
          dev_q           <= dev_c;
          io_q            <= io_c;
          int_q           <= int_c;
          DEVICE_SELECT_N <= ~dev_c;
          IO_SELECT_N     <= ~io_c;
          IO_STROBE_N     <= ~strb_c;
          state           <= ACTIVE;
        end
        ACTIVE: if (ph2_fall) begin
          DEVICE_SELECT_N <= '1;
          IO_SELECT_N     <= '1;
          IO_STROBE_N     <= 1'b1;
          state           <= HOLD;
        end
        HOLD: begin
          // A PH_2 rise seen here is dropped; the next cycle needs a fresh rise.
          state <= IDLE;
          if (!rw_q) begin
            case (addr_q)
              ADDR_INTCXROM_OFF: intcxrom  <= 1'b0;
              ADDR_INTCXROM_ON:  intcxrom  <= 1'b1;
              ADDR_SLOTC3_OFF:   slotc3rom <= 1'b0;
              ADDR_SLOTC3_ON:    slotc3rom <= 1'b1;
              default: ;
            endcase
          end
          if ((addr_q[15:8] == 8'hC3) && !slotc3rom) intc8rom <= 1'b1;
          if (|io_q) C8_OWNER <= addr_q[10:8];
          // CFFF release overrides any ownership claim in the same cycle.
          if (addr_q == ADDR_C8_RELEASE) begin
            C8_OWNER <= '0;
            intc8rom <= 1'b0;
          end
          if (rw_q) begin
            BUS_DO       <= rd_data;
            INT_ROM_SEL  <= int_q;
            BUS_DO_VALID <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_14M) begin
    if (RESET) irq_pipe <= 2'b11;
    else       irq_pipe <= {irq_pipe[0], &(CARD_IRQ_N | ~SLOT_MASK)};
  end

  assign IRQ_N = irq_pipe[1];

endmodule

// File: tb/tb_apple2_slot_bus.sv
// Self-checking bench for apple2_slot_bus: directed scenarios then randomized bus cycles.
module tb_apple2_slot_bus;

  localparam logic [6:0] MASK = 7'h5F;  // slot 6 left empty

  logic        CLK_14M = 1'b0;
  logic        RESET = 1'b1;
  logic        PH_2 = 1'b0;
  logic [15:0] ADDRESS = '0;
  logic        RW_N = 1'b1;
  logic [55:0] CARD_DO = '0;
  logic [6:0]  CARD_ROM_EN = '0;
  logic [6:0]  CARD_IRQ_N = '1;
  logic [6:0]  DEVICE_SELECT_N, IO_SELECT_N;
  logic        IO_STROBE_N, BUS_DO_VALID, INT_ROM_SEL, IRQ_N;
  logic [7:0]  BUS_DO;
  logic [2:0]  C8_OWNER;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  bit         m_cx, m_c3, m_c8, m_introm;
  int         m_owner;
  logic [7:0] m_busdo;

  always #5 CLK_14M = ~CLK_14M;

  apple2_slot_bus #(.SLOT_MASK(MASK)) dut (
    .CLK_14M(CLK_14M), .RESET(RESET), .PH_2(PH_2), .ADDRESS(ADDRESS), .RW_N(RW_N),
    .CARD_DO(CARD_DO), .CARD_ROM_EN(CARD_ROM_EN), .CARD_IRQ_N(CARD_IRQ_N),
    .DEVICE_SELECT_N(DEVICE_SELECT_N), .IO_SELECT_N(IO_SELECT_N), .IO_STROBE_N(IO_STROBE_N),
    .BUS_DO(BUS_DO), .BUS_DO_VALID(BUS_DO_VALID), .INT_ROM_SEL(INT_ROM_SEL),
    .IRQ_N(IRQ_N), .C8_OWNER(C8_OWNER)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_cx = 0; m_c3 = 0; m_c8 = 0; m_introm = 0; m_owner = 0; m_busdo = 8'h00;
  endfunction

  function automatic bit in_range(input logic [15:0] a, input int lo, input int hi);
    return (int'(a) >= lo) && (int'(a) <= hi);
  endfunction

  // {DEVICE_SELECT_N, IO_SELECT_N, IO_STROBE_N} expected while the cycle is active
  function automatic logic [14:0] exp_strobes(input logic [15:0] a);
    logic [6:0] ds, io;
    logic       st;
    int         n;
    ds = '1; io = '1; st = 1'b1;
    if (in_range(a, 'hC080, 'hC0FF)) begin
      n = (int'(a) - 'hC080) / 16;
      if (n > 0 && MASK[n-1]) ds[n-1] = 1'b0;
    end else if (in_range(a, 'hC100, 'hC7FF)) begin
      n = (int'(a) - 'hC000) / 256;
      if (!(m_cx || (n == 3 && !m_c3)) && MASK[n-1]) io[n-1] = 1'b0;
    end else if (in_range(a, 'hC800, 'hCFFF)) begin
      if (!m_cx && !m_c8) st = 1'b0;
    end
    return {ds, io, st};
  endfunction

  function automatic bit exp_internal(input logic [15:0] a);
    int n;
    n = (int'(a) - 'hC000) / 256;
    if (in_range(a, 'hC100, 'hC7FF)) return m_cx || (n == 3 && !m_c3);
    if (in_range(a, 'hC800, 'hCFFF)) return m_cx || m_c8;
    return 1'b0;
  endfunction

  function automatic logic [7:0] card_byte(input int n);
    return CARD_DO[8*(n-1) +: 8];
  endfunction

  function automatic logic [7:0] exp_read(input logic [15:0] a);
    logic [14:0] s;
    s = exp_strobes(a);
    if (exp_internal(a)) return 8'hFF;
    for (int n = 1; n <= 7; n++)
      if (!s[7+n] || !s[n]) return card_byte(n);
    if (in_range(a, 'hC800, 'hCFFF) && m_owner != 0 && CARD_ROM_EN[m_owner-1] && MASK[m_owner-1])
      return card_byte(m_owner);
    return 8'hFF;
  endfunction

  function automatic void model_update(input logic [15:0] a, input logic rw);
    logic [14:0] s;
    s = exp_strobes(a);
    if (!rw) begin
      if (a == 16'hC006) m_cx = 0;
      if (a == 16'hC007) m_cx = 1;
      if (a == 16'hC00A) m_c3 = 0;
      if (a == 16'hC00B) m_c3 = 1;
    end
    if (a[15:8] == 8'hC3 && !m_c3) m_c8 = 1;
    for (int n = 1; n <= 7; n++) if (!s[n]) m_owner = n;
    if (a == 16'hCFFF) begin m_owner = 0; m_c8 = 0; end
  endfunction

  function automatic logic [14:0] strobes();
    return {DEVICE_SELECT_N, IO_SELECT_N, IO_STROBE_N};
  endfunction

  // One PH_2-framed bus cycle; short_low re-raises PH_2 during HOLD.
  task automatic bus_cycle(input logic [15:0] a, input logic rw, input int act, input bit short_low);
    logic [14:0] es;
    logic [7:0]  ed;
    bit          ei;
    @(negedge CLK_14M);
    ADDRESS = a; RW_N = rw; PH_2 = 1'b1;
    es = exp_strobes(a); ei = exp_internal(a); ed = exp_read(a);
    @(negedge CLK_14M);
    chk("strobe_rise", 32'(strobes()), 32'(es));
    ADDRESS = 16'($urandom); RW_N = 1'($urandom);
    repeat (act) @(negedge CLK_14M);
    chk("strobe_active", 32'(strobes()), 32'(es));
    PH_2 = 1'b0;
    @(negedge CLK_14M);
    chk("strobe_hold", 32'(strobes()), 32'h7FFF);
    chk("valid_in_hold", 32'(BUS_DO_VALID), 32'd0);
    if (short_low) PH_2 = 1'b1;
    model_update(a, rw);
    if (rw) begin m_busdo = ed; m_introm = ei; end
    @(negedge CLK_14M);
    chk("valid_pulse", 32'(BUS_DO_VALID), 32'(rw));
    chk("bus_do", 32'(BUS_DO), 32'(m_busdo));
    chk("int_rom_sel", 32'(INT_ROM_SEL), 32'(m_introm));
    chk("c8_owner", 32'(C8_OWNER), 32'(m_owner));
    @(negedge CLK_14M);
    chk("valid_end", 32'(BUS_DO_VALID), 32'd0);
    chk("strobe_idle", 32'(strobes()), 32'h7FFF);
    PH_2 = 1'b0;
  endtask

  task automatic set_card(input int n, input logic [7:0] v);
    CARD_DO[8*(n-1) +: 8] = v;
  endtask

  initial begin
    logic [15:0] a;
    logic        rw;
    model_reset();
    repeat (3) @(negedge CLK_14M);
    chk("rst_strobes", 32'(strobes()), 32'h7FFF);
    chk("rst_bus_do", 32'(BUS_DO), 32'h00);
    chk("rst_valid", 32'(BUS_DO_VALID), 32'd0);
    chk("rst_int_rom", 32'(INT_ROM_SEL), 32'd0);
    chk("rst_owner", 32'(C8_OWNER), 32'd0);
    chk("rst_irq", 32'(IRQ_N), 32'd1);
    RESET = 1'b0;

    // Device select slot 2
    CARD_DO = 56'({$urandom(), $urandom()});
    set_card(2, 8'h5A);
    bus_cycle(16'hC0A9, 1'b1, 2, 1'b0);
    chk("c0a9_data", 32'(BUS_DO), 32'h5A);

    // C800 ownership by slot 2
    CARD_ROM_EN = 7'h02;
    bus_cycle(16'hC205, 1'b1, 1, 1'b0);
    set_card(2, 8'h3C);
    bus_cycle(16'hC805, 1'b1, 1, 1'b0);
    chk("c805_owner", 32'(C8_OWNER), 32'd2);
    chk("c805_data", 32'(BUS_DO), 32'h3C);

    // CFFF release
    bus_cycle(16'hCFFF, 1'b1, 1, 1'b0);
    bus_cycle(16'hC805, 1'b1, 1, 1'b0);
    chk("release_owner", 32'(C8_OWNER), 32'd0);
    chk("release_data", 32'(BUS_DO), 32'hFF);

    // INTCXROM on/off
    bus_cycle(16'hC007, 1'b0, 1, 1'b0);
    bus_cycle(16'hC200, 1'b1, 1, 1'b0);
    chk("cx_int_rom", 32'(INT_ROM_SEL), 32'd1);
    bus_cycle(16'hC006, 1'b0, 1, 1'b0);
    bus_cycle(16'hC200, 1'b1, 1, 1'b0);
    chk("cx_off_int_rom", 32'(INT_ROM_SEL), 32'd0);

    // Internal C3 and C8 takeover
    bus_cycle(16'hC300, 1'b1, 1, 1'b0);
    bus_cycle(16'hC800, 1'b1, 1, 1'b0);
    chk("c8_int_rom", 32'(INT_ROM_SEL), 32'd1);

    // Unpopulated slot 6, then a PH_2 rise inside HOLD
    bus_cycle(16'hC0E3, 1'b1, 1, 1'b0);
    bus_cycle(16'hC610, 1'b1, 1, 1'b0);
    bus_cycle(16'hC0A0, 1'b1, 2, 1'b1);

    // IRQ combining through synchronizer
    CARD_IRQ_N = 7'h5F;
    repeat (3) @(negedge CLK_14M);
    chk("irq_masked", 32'(IRQ_N), 32'd1);
    CARD_IRQ_N = 7'h7E;
    repeat (3) @(negedge CLK_14M);
    chk("irq_slot1", 32'(IRQ_N), 32'd0);

    // Reset in the middle of an active cycle
    @(negedge CLK_14M);
    ADDRESS = 16'hC0A9; RW_N = 1'b1; PH_2 = 1'b1;
    @(negedge CLK_14M);
    chk("rst_mid_sel", 32'(DEVICE_SELECT_N), 32'h7D);
    RESET = 1'b1;
    @(negedge CLK_14M);
    chk("rst_mid_strobes", 32'(strobes()), 32'h7FFF);
    chk("rst_mid_valid", 32'(BUS_DO_VALID), 32'd0);
    chk("rst_mid_owner", 32'(C8_OWNER), 32'd0);
    model_reset();
    PH_2 = 1'b0;
    @(negedge CLK_14M);
    RESET = 1'b0;
    repeat (3) begin
      @(negedge CLK_14M);
      chk("rst_mid_novalid", 32'(BUS_DO_VALID), 32'd0);
    end

    // Randomized bus traffic
    for (int i = 0; i < 120; i++) begin
      CARD_DO     = 56'({$urandom(), $urandom()});
      CARD_ROM_EN = 7'($urandom);
      CARD_IRQ_N  = 7'($urandom);
      rw = 1'($urandom);
      case ($urandom_range(0, 6))
        0: a = 16'(32'hC080 + $urandom_range(0, 127));
        1: a = 16'(32'hC000 + 256 * $urandom_range(1, 7) + $urandom_range(0, 255));
        2: a = 16'(32'hC800 + $urandom_range(0, 2047));
        3: a = 16'hCFFF;
        4: begin
          case ($urandom_range(0, 3))
            0: a = 16'hC006;
            1: a = 16'hC007;
            2: a = 16'hC00A;
            default: a = 16'hC00B;
          endcase
          rw = 1'b0;
        end
        5: a = 16'(32'hC300 + $urandom_range(0, 255));
        default: a = 16'($urandom_range(0, 32'hBFFF));
      endcase
      bus_cycle(a, rw, int'($urandom_range(1, 3)), 1'($urandom_range(0, 3) == 0));
      chk("irq_rand", 32'(IRQ_N), 32'(&(CARD_IRQ_N | ~MASK)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
